// File: rtl/draw_screen.sv
// draw_screen: rasters a full image from the image ROM into the VGA adapter.
// The ROM has one cycle of read latency. The VGA coordinates are registered
// so they line up with rom_data: the pixel issued in cycle k is plotted in
// cycle k+1. FLUSH gives the last issued pixel one more cycle to be plotted.
module draw_screen #(
    parameter int H_PIX = 160,
    parameter int V_PIX = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        drawScreenEnable,
    input  logic [1:0]  ScreenSelect,
    input  logic [2:0]  rom_data,
    output logic [14:0] rom_addr,
    output logic [1:0]  rom_sel,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        drawScreenDone
);

    localparam logic [7:0] X_MAX   = 8'(H_PIX - 1);
    localparam logic [6:0] Y_MAX   = 7'(V_PIX - 1);
    localparam logic [1:0] SEL_RST = 2'd2;   // START screen

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

    state_t     state;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] sel_q;

    // The ROM address is taken from the issue counters at full width, so the
    // ROM sees the pixel in the same cycle that the pixel is issued.
    assign rom_addr = 15'(y) * 15'(H_PIX) + 15'(x);
    assign rom_sel  = sel_q;

    // rom_data already lines up with the registered coordinates. The colour
    // is forced to 0 when nothing is plotted, so the port reads 0 after reset.
    assign vga_colour = vga_plot ? rom_data : 3'd0;

    // Control FSM with raster counters and registered VGA strobe/coords.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            x              <= '0;
            y              <= '0;
            sel_q          <= SEL_RST;
            vga_x          <= '0;
            vga_y          <= '0;
            vga_plot       <= 1'b0;
            drawScreenDone <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (drawScreenEnable) begin
                        sel_q <= ScreenSelect;
                        x     <= '0;
                        y     <= '0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    // Plot next cycle whatever is issued now.
                    vga_x    <= x;
                    vga_y    <= y;
                    vga_plot <= 1'b1;
                    if (x == X_MAX) begin
                        x <= '0;
                        if (y == Y_MAX) begin
                            y     <= '0;
                            state <= FLUSH;
                        end else begin
                            y <= y + 7'd1;
                        end
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                FLUSH: begin
                    state          <= DONE;
                    drawScreenDone <= 1'b1;
                end
                DONE: begin
                    // Redraw only when a different image is requested.
                    if (drawScreenEnable && (ScreenSelect != sel_q)) begin
                        sel_q          <= ScreenSelect;
                        x              <= '0;
                        y              <= '0;
                        state          <= DRAW;
                        drawScreenDone <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_screen.sv
// Bench for draw_screen. A ROM model returns (addr mod 8) one cycle late.
// Each cycle is checked against the raster order of the image: the n-th
// cycle after a start edge plots pixel n-1.
module tb_draw_screen;

    localparam int H = 160;
    localparam int V = 120;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        resetn;
    logic        drawScreenEnable;
    logic [1:0]  ScreenSelect;
    logic [2:0]  rom_data;
    logic [14:0] rom_addr;
    logic [1:0]  rom_sel;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        drawScreenDone;

    int vectors = 0;
    int miscompares = 0;

    draw_screen #(.H_PIX(H), .V_PIX(V)) dut (
        .clk(clk), .resetn(resetn), .drawScreenEnable(drawScreenEnable),
        .ScreenSelect(ScreenSelect), .rom_data(rom_data), .rom_addr(rom_addr),
        .rom_sel(rom_sel), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .drawScreenDone(drawScreenDone)
    );

    always #5 clk = ~clk;

    // ROM model: one cycle of latency, contents = address mod 8.
    always @(posedge clk) rom_data <= 3'(int'(rom_addr) % 8);

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drawScreenEnable = 1'($urandom);
            ScreenSelect     = 2'($urandom);
            @(negedge clk);
            vectors++;
            if (vga_plot !== 1'b0 || drawScreenDone !== 1'b0 || rom_addr !== 15'd0 ||
                rom_sel !== 2'd2 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
                miscompares++;
                $display("FAIL reset: plot=%0b done=%0b addr=%0d sel=%0d x=%0d y=%0d c=%0d, want all 0 and sel=2",
                         vga_plot, drawScreenDone, rom_addr, rom_sel, vga_x, vga_y, vga_colour);
            end
        end
        resetn = 1'b1;
        drawScreenEnable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (vga_plot !== 1'b0 || drawScreenDone !== 1'b0) begin
                miscompares++;
                $display("FAIL idle: plot=%0b done=%0b, want 0 0", vga_plot, drawScreenDone);
            end
        end
    endtask

    // Full draw of START from IDLE, enable held high throughout.
    task automatic test_full_draw();
        int px;
        drawScreenEnable = 1'b1;
        ScreenSelect     = 2'd2;
        for (int n = 0; n <= NPIX + 1; n++) begin
            @(negedge clk);
            px = n - 1;
            vectors++;
            if (vga_plot !== 1'((n >= 1) && (n <= NPIX))) begin
                miscompares++;
                if (miscompares < 30) $display("FAIL full_plot cycle %0d: got %0b", n, vga_plot);
            end
            vectors++;
            if (drawScreenDone !== 1'(n == NPIX + 1)) begin
                miscompares++;
                if (miscompares < 30) $display("FAIL full_done cycle %0d: got %0b", n, drawScreenDone);
            end
            vectors++;
            if (rom_sel !== 2'd2) begin
                miscompares++;
                if (miscompares < 30) $display("FAIL full_sel cycle %0d: got %0d want 2", n, rom_sel);
            end
            if (n < NPIX) begin
                vectors++;
                if (rom_addr !== 15'(n)) begin
                    miscompares++;
                    if (miscompares < 30) $display("FAIL full_addr cycle %0d: got %0d want %0d", n, rom_addr, n);
                end
            end
            if (n >= 1 && n <= NPIX) begin
                vectors++;
                if (vga_x !== 8'(px % H) || vga_y !== 7'(px / H) || vga_colour !== 3'(px % 8)) begin
                    miscompares++;
                    if (miscompares < 30)
                        $display("FAIL full_pix cycle %0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 n, vga_x, vga_y, vga_colour, px % H, px / H, px % 8);
                end
            end
        end
    endtask

    // From DONE(2), request MAP1; enable and select wander during the draw.
    task automatic test_switch();
        int px;
        drawScreenEnable = 1'b1;
        ScreenSelect     = 2'd0;
        for (int n = 0; n <= NPIX + 1; n++) begin
            @(negedge clk);
            px = n - 1;
            vectors++;
            if (drawScreenDone !== 1'(n == NPIX + 1)) begin
                miscompares++;
                if (miscompares < 30) $display("FAIL switch_done cycle %0d: got %0b", n, drawScreenDone);
            end
            vectors++;
            if (rom_sel !== 2'd0) begin
                miscompares++;
                if (miscompares < 30) $display("FAIL switch_sel cycle %0d: got %0d want 0", n, rom_sel);
            end
            vectors++;
            if (vga_plot !== 1'((n >= 1) && (n <= NPIX))) begin
                miscompares++;
                if (miscompares < 30) $display("FAIL switch_plot cycle %0d: got %0b", n, vga_plot);
            end
            if (n == 1 || n == NPIX || (n > 1 && n < NPIX && $urandom_range(0, 63) == 0)) begin
                vectors++;
                if (vga_x !== 8'(px % H) || vga_y !== 7'(px / H) || vga_colour !== 3'(px % 8)) begin
                    miscompares++;
                    if (miscompares < 30)
                        $display("FAIL switch_pix cycle %0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 n, vga_x, vga_y, vga_colour, px % H, px / H, px % 8);
                end
            end
            // Enable drops right after the start; afterwards inputs are noise
            // until the DONE cycle, where they go quiet.
            if (n == 0 || n + 1 >= NPIX + 1) begin
                drawScreenEnable = 1'b0;
                ScreenSelect     = (n == 0) ? 2'd3 : 2'd0;
            end else begin
                drawScreenEnable = 1'($urandom);
                ScreenSelect     = 2'($urandom);
            end
        end
    endtask

    // In DONE(0), requests for the same image never redraw.
    task automatic test_hold();
        for (int i = 0; i < 100; i++) begin
            drawScreenEnable = (i < 50) ? 1'b1 : 1'($urandom);
            ScreenSelect     = (i < 50 || drawScreenEnable) ? 2'd0 : 2'($urandom);
            @(negedge clk);
            vectors++;
            if (drawScreenDone !== 1'b1 || vga_plot !== 1'b0) begin
                miscompares++;
                if (miscompares < 30) $display("FAIL hold cycle %0d: done=%0b plot=%0b, want 1 0", i, drawScreenDone, vga_plot);
            end
        end
    endtask

    // Reset at plot 5000 aborts the draw; the block then waits in IDLE.
    task automatic test_reset_mid();
        logic [1:0] s;
        s = 2'($urandom_range(1, 3));
        drawScreenEnable = 1'b1;
        ScreenSelect     = s;
        for (int n = 0; n <= 5000; n++) begin
            @(negedge clk);
            if (n == 5000) begin
                vectors++;
                if (vga_plot !== 1'b1 || vga_x !== 8'(4999 % H) || vga_y !== 7'(4999 / H) || rom_sel !== s) begin
                    miscompares++;
                    $display("FAIL mid_plot5000: got plot=%0b (%0d,%0d) sel=%0d want 1 (%0d,%0d) sel=%0d",
                             vga_plot, vga_x, vga_y, rom_sel, 4999 % H, 4999 / H, s);
                end
            end
            drawScreenEnable = 1'($urandom);
        end
        resetn = 1'b0;
        @(negedge clk);
        vectors++;
        if (vga_plot !== 1'b0 || drawScreenDone !== 1'b0 || rom_addr !== 15'd0 || rom_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL mid_reset: plot=%0b done=%0b addr=%0d sel=%0d want 0 0 0 2",
                     vga_plot, drawScreenDone, rom_addr, rom_sel);
        end
        resetn = 1'b1;
        drawScreenEnable = 1'b0;
        ScreenSelect = 2'($urandom);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            vectors++;
            if (vga_plot !== 1'b0 || drawScreenDone !== 1'b0) begin
                miscompares++;
                if (miscompares < 30) $display("FAIL post_reset cycle %0d: plot=%0b done=%0b want 0 0", i, vga_plot, drawScreenDone);
            end
        end
        // A fresh start from IDLE: no plot in the first cycle, then pixel (0,0).
        s = 2'($urandom);
        drawScreenEnable = 1'b1;
        ScreenSelect     = s;
        @(negedge clk);
        vectors++;
        if (vga_plot !== 1'b0 || rom_sel !== s || rom_addr !== 15'd0) begin
            miscompares++;
            $display("FAIL restart_first: plot=%0b sel=%0d addr=%0d want 0 %0d 0", vga_plot, rom_sel, rom_addr, s);
        end
        @(negedge clk);
        vectors++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
            miscompares++;
            $display("FAIL restart_pix: plot=%0b (%0d,%0d,c%0d) want 1 (0,0,c0)", vga_plot, vga_x, vga_y, vga_colour);
        end
    endtask

    initial begin
        resetn           = 1'b0;
        drawScreenEnable = 1'b0;
        ScreenSelect     = 2'd0;
        @(negedge clk);
        test_reset();
        test_full_draw();
        test_switch();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/draw_screen.md
DRAW_SCREEN -- requirements
Module: draw_screen

Interface
REQ-001 SHALL have parameters: H_PIX, default 160, screen width in pixels; V_PIX, default 120, screen height in pixels.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port drawScreenEnable  input  1  level request to draw a full screen.
REQ-005 SHALL have port ScreenSelect  input  2  image to draw: 0 MAP1, 1 MAP2, 2 START, 3 GG.
REQ-006 SHALL have port rom_data  input  3  pixel colour from the image ROM, valid 1 cycle after rom_addr/rom_sel.
REQ-007 SHALL have port rom_addr  output  15  ROM address = y*H_PIX + x.
REQ-008 SHALL have port rom_sel  output  2  latched screen select that steers the ROM mux.
REQ-009 SHALL have port vga_x  output  8  pixel column to the VGA adapter.
REQ-010 SHALL have port vga_y  output  7  pixel row to the VGA adapter.
REQ-011 SHALL have port vga_colour  output  3  pixel colour, equal to rom_data.
REQ-012 SHALL have port vga_plot  output  1  write strobe to the VGA adapter.
REQ-013 SHALL have port drawScreenDone  output  1  level, high while a completed image is held and no redraw is pending.

Function
REQ-014 SHALL implement a state machine with states IDLE, DRAW, FLUSH and DONE.
REQ-015 In IDLE, drawScreenEnable=1 SHALL latch ScreenSelect into sel_q, clear x and y, and enter DRAW.
REQ-016 In DRAW, each cycle SHALL drive rom_addr=y*H_PIX+x and rom_sel=sel_q.
REQ-017 In DRAW, x SHALL increment each cycle; at x=H_PIX-1, x SHALL wrap to 0 and y SHALL increment.
REQ-018 In DRAW, at x=H_PIX-1 and y=V_PIX-1, the next state SHALL be FLUSH.
REQ-019 Issue pipeline: coordinates issued in cycle k SHALL appear on vga_x/vga_y in cycle k+1 with vga_plot=1 and vga_colour=rom_data.
REQ-020 FLUSH SHALL last 1 cycle: it plots the last pixel, then enters DONE.
REQ-021 A full draw SHALL take exactly H_PIX*V_PIX+1 cycles (19201 with defaults), counted from the cycle after the start edge up to the first DONE cycle.
REQ-022 In DONE, drawScreenDone SHALL be 1; in every other state it SHALL be 0.
REQ-023 In DONE, drawScreenEnable=1 with ScreenSelect!=sel_q SHALL latch the new select, clear x and y, and enter DRAW, so drawScreenDone falls on the next cycle.
REQ-024 In DONE, drawScreenEnable=1 with ScreenSelect==sel_q SHALL hold DONE (no redraw).
REQ-025 In DONE, drawScreenEnable=0 SHALL hold DONE.
REQ-026 Once started, a draw SHALL run to completion regardless of drawScreenEnable.
REQ-027 Changes to ScreenSelect during DRAW or FLUSH SHALL be ignored; sel_q is sampled only at a start.
REQ-028 vga_plot SHALL be 0 in IDLE and DONE, and in the first DRAW cycle of each draw.
REQ-029 rom_addr SHALL be computed at full 15-bit width; the maximum value is 19199 with defaults, with no overflow.

Reset
REQ-030 While resetn=0 at a clock edge, the block SHALL set state=IDLE, x=0, y=0, sel_q=2 (START), rom_addr=0, rom_sel=2, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0 and drawScreenDone=0.
REQ-031 Reset asserted mid-DRAW SHALL abort the draw with no further plots; after release the block SHALL wait in IDLE for drawScreenEnable.

Verification
REQ-032 Reset, then enable=1, sel=2 -> exactly 19200 plots covering every (x,y) once in raster order with rom_sel=2; done=1 at cycle 19201, not before.
REQ-033 In DONE(sel 2), hold enable=1 and switch sel to 0 -> done=0 next cycle; drawing stays active with enable dropped the following cycle; done=1 again after 19201 cycles with rom_sel=0.
REQ-034 In DONE(sel 0), enable=1, sel=0 for 100 cycles -> done stays 1, vga_plot stays 0.
REQ-035 During DRAW, toggle sel 0->3 -> rom_sel stays 0 for the whole draw.
REQ-036 Assert resetn=0 at plot 5000 -> next cycle vga_plot=0, done=0, state=IDLE; after release with enable=0 -> no plots for 50 cycles.
REQ-037 ROM model returning (addr mod 8) with 1-cycle latency -> each plot satisfies vga_colour==(vga_y*160+vga_x) mod 8; first plot at (0,0), last plot at (159,119).
